d_sum_stage: RTL and testbench

D_SUM_STAGE -- requirements
Module: d_sum_stage

---
 rtl/d_sum_stage_if.sv | 23 ++
 rtl/d_sum_stage.sv | 113 +++++++++++
 tb/tb_d_sum_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_sum_stage_if.sv
// Handshake bundle between the upstream item source, d_sum_stage and the packet consumer.
interface d_sum_stage_if #(
  parameter int unsigned DW = 3
);
  logic          d_valid;
  logic [DW-1:0] d_data;
  logic          d_ready;
  logic          sum_valid;
  logic [6:0]    sum_data;
  logic [DW-1:0] sum_max;
  logic          sum_ready;
  logic [3:0]    state;

  modport master (
    output d_valid, d_data, sum_ready,
    input  d_ready, sum_valid, sum_data, sum_max, state
  );

  modport slave (
    input  d_valid, d_data, sum_ready,
    output d_ready, sum_valid, sum_data, sum_max, state
  );
endinterface

// File: rtl/d_sum_stage.sv
// Buffers items in a 2-entry FIFO, accumulates sum and max over N items, then presents
// the packet result until the consumer takes it.
module d_sum_stage #(
  parameter int unsigned N  = 10,
  parameter int unsigned DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  d_sum_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    StAccum = 4'h1,
    StEmit  = 4'h2
  } state_e;

  state_e        state_q, state_d;

  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;
  logic          push, pop;
  logic [DW-1:0] item;

  logic [6:0]    sum_q, sum_next;
  logic [DW-1:0] max_q, max_next;
  logic [3:0]    cnt_q;
  logic          last;
  logic [6:0]    sum_data_q;
  logic [DW-1:0] sum_max_q;

  // Ready depends only on registered occupancy; reset forces it low.
  assign bus.d_ready = ~rst & (count != 2'd2);
  assign push        = bus.d_valid & bus.d_ready;
  assign pop         = (state_q == StAccum) & (count != 2'd0);
  assign item        = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.d_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    sum_next = sum_q + 7'(item);
    max_next = (item > max_q) ? item : max_q;
    last     = pop & (cnt_q == 4'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      sum_data_q <= '0;
      sum_max_q  <= '0;
    end else if (pop) begin
      if (last) begin
        sum_data_q <= sum_next;
        sum_max_q  <= max_next;
        sum_q      <= '0;
        max_q      <= '0;
        cnt_q      <= '0;
      end else begin
        sum_q <= sum_next;
        max_q <= max_next;
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Unknown codes fall back to accumulation on the next edge.
  always_comb begin
    state_d = StAccum;
    case (state_q)
      StAccum: state_d = last ? StEmit : StAccum;
      StEmit:  state_d = bus.sum_ready ? StAccum : StEmit;
      default: state_d = StAccum;
    endcase
  end

  always_comb begin
    bus.sum_valid = (state_q == StEmit);
    bus.sum_data  = sum_data_q;
    bus.sum_max   = sum_max_q;
    bus.state     = state_q;
  end

endmodule

// File: tb/tb_d_sum_stage.sv
// Random and directed stimulus on an N=10 and an N=1 instance, scoreboarded against a
// packet-level model that groups accepted items into runs of N.
module tb_d_sum_stage;

  typedef struct packed {
    logic [6:0] s;
    logic [2:0] m;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  d_sum_stage_if #(.DW(3)) b0 ();
  d_sum_stage_if #(.DW(3)) b1 ();

  d_sum_stage #(.N(10), .DW(3)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  d_sum_stage #(.N(1),  .DW(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [2:0] src0[$], src1[$];
  pkt_t       exp0[$], exp1[$], obs0[$], obs1[$];
  int         n_of[2], part_sum[2], part_max[2], part_cnt[2], acc_cnt[2];
  int         vld_pct[2], rdy_pct[2];
  logic       hold_v[2];
  pkt_t       hold_p[2];
  int         checks = 0, failures = 0, cyc = 0;
  int         first_valid0 = -1, last_acc_cyc0 = 0;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_push(input int k, input int itm);
    pkt_t p;
    part_sum[k] += itm;
    if (itm > part_max[k]) part_max[k] = itm;
    part_cnt[k]++;
    acc_cnt[k]++;
    if (part_cnt[k] == n_of[k]) begin
      p.s = 7'(part_sum[k]);
      p.m = 3'(part_max[k]);
      if (k == 0) exp0.push_back(p); else exp1.push_back(p);
      part_sum[k] = 0;
      part_max[k] = 0;
      part_cnt[k] = 0;
    end
  endtask

  task automatic model_clear();
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    for (int k = 0; k < 2; k++) begin
      part_sum[k] = 0; part_max[k] = 0; part_cnt[k] = 0; hold_v[k] = 1'b0;
    end
  endtask

  task automatic observe(input int k);
    logic dv, dr, sv, sr;
    logic [2:0] dd, sm;
    logic [6:0] sd;
    logic [3:0] st;
    int nexp;
    pkt_t e, o;
    dv = (k == 0) ? b0.d_valid   : b1.d_valid;
    dr = (k == 0) ? b0.d_ready   : b1.d_ready;
    dd = (k == 0) ? b0.d_data    : b1.d_data;
    sv = (k == 0) ? b0.sum_valid : b1.sum_valid;
    sr = (k == 0) ? b0.sum_ready : b1.sum_ready;
    sd = (k == 0) ? b0.sum_data  : b1.sum_data;
    sm = (k == 0) ? b0.sum_max   : b1.sum_max;
    st = (k == 0) ? b0.state     : b1.state;
    nexp = (k == 0) ? exp0.size() : exp1.size();
    chk("state_code", int'(st), sv ? 2 : 1);
    // While presenting, nothing is mid-accumulation, so model backlog equals FIFO fill.
    if (sv && nexp > 0)
      chk("ready_vs_fill", int'(dr), (((nexp - 1) * n_of[k] + part_cnt[k]) < 2) ? 1 : 0);
    if (hold_v[k]) begin
      chk("hold_valid", int'(sv), 1);
      chk("hold_sum", int'(sd), int'(hold_p[k].s));
      chk("hold_max", int'(sm), int'(hold_p[k].m));
    end
    if (sv && sr) begin
      o.s = sd;
      o.m = sm;
      if (nexp == 0) begin
        chk("spurious_packet", 1, 0);
      end else begin
        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        chk("pkt_sum", int'(sd), int'(e.s));
        chk("pkt_max", int'(sm), int'(e.m));
      end
      if (k == 0) obs0.push_back(o); else obs1.push_back(o);
    end
    hold_v[k]   = sv && !sr;
    hold_p[k].s = sd;
    hold_p[k].m = sm;
    if (dv && dr) begin
      if (k == 0) begin
        void'(src0.pop_front());
        last_acc_cyc0 = cyc;
      end else begin
        void'(src1.pop_front());
      end
      model_push(k, int'(dd));
    end
    if (k == 0 && sv && first_valid0 < 0) first_valid0 = cyc;
  endtask

  task automatic drive();
    b0.d_valid   = (src0.size() > 0) && ($urandom_range(99) < vld_pct[0]);
    b0.d_data    = b0.d_valid ? src0[0] : 3'($urandom);
    b0.sum_ready = $urandom_range(99) < rdy_pct[0];
    b1.d_valid   = (src1.size() > 0) && ($urandom_range(99) < vld_pct[1]);
    b1.d_data    = b1.d_valid ? src1[0] : 3'($urandom);
    b1.sum_ready = $urandom_range(99) < rdy_pct[1];
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    cyc++;
    observe(0);
    observe(1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic drain(input string tag, input int budget);
    int i = 0;
    while (!(src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 && exp1.size() == 0)
           && i < budget) begin
      step();
      i++;
    end
    chk(tag, (i < budget) ? 1 : 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_d_ready0"}, int'(b0.d_ready), 0);
    chk({tag, "_valid0"}, int'(b0.sum_valid), 0);
    chk({tag, "_sum0"}, int'(b0.sum_data), 0);
    chk({tag, "_max0"}, int'(b0.sum_max), 0);
    chk({tag, "_state0"}, int'(b0.state), 1);
    chk({tag, "_d_ready1"}, int'(b1.d_ready), 0);
    chk({tag, "_valid1"}, int'(b1.sum_valid), 0);
  endtask

  // Entered just after a rising edge; rst is raised between edges.
  task automatic do_reset(input string tag);
    b0.d_valid = 1'b0; b0.sum_ready = 1'b0;
    b1.d_valid = 1'b0; b1.sum_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs(tag);
    model_clear();
    @(posedge clk);
    #1 chk_reset_outputs({tag, "_held"});
    rst = 1'b0;
    #1;
    chk({tag, "_rel_ready0"}, int'(b0.d_ready), 1);
    chk({tag, "_rel_ready1"}, int'(b1.d_ready), 1);
  endtask

  initial begin
    int a;
    n_of[0] = 10;
    n_of[1] = 1;
    for (int k = 0; k < 2; k++) begin
      acc_cnt[k] = 0; vld_pct[k] = 100; rdy_pct[k] = 100;
    end
    model_clear();
    b0.d_valid = 1'b0; b0.d_data = '0; b0.sum_ready = 1'b0;
    b1.d_valid = 1'b0; b1.d_data = '0; b1.sum_ready = 1'b0;
    @(posedge clk);
    #1 do_reset("init");

    // Ten 7s back-to-back; N=1 instance gets 3,6,2 with random output stalls.
    for (int i = 0; i < 10; i++) src0.push_back(3'd7);
    src1.push_back(3'd3); src1.push_back(3'd6); src1.push_back(3'd2);
    rdy_pct[1] = 50;
    first_valid0 = -1;
    drain("t1_drain", 200);
    // Handshake seen at negedge c is pushed at the next edge, popped one edge later.
    chk("t1_latency", first_valid0 - last_acc_cyc0, 2);
    chk("t1_count", obs0.size(), 1);
    if (obs0.size() == 1) begin
      chk("t1_sum", int'(obs0[0].s), 70);
      chk("t1_max", int'(obs0[0].m), 7);
    end
    chk("n1_count", obs1.size(), 3);
    if (obs1.size() == 3) begin
      chk("n1_p0", int'(obs1[0].s) * 8 + int'(obs1[0].m), 3 * 8 + 3);
      chk("n1_p1", int'(obs1[1].s) * 8 + int'(obs1[1].m), 6 * 8 + 6);
      chk("n1_p2", int'(obs1[2].s) * 8 + int'(obs1[2].m), 2 * 8 + 2);
    end

    // Two identical bursts 0..7,0,1 with random gaps.
    obs0.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 10; i++) src0.push_back(3'(i % 8));
    vld_pct[0] = 60; rdy_pct[0] = 70;
    drain("t2_drain", 400);
    chk("t2_count", obs0.size(), 2);
    for (int i = 0; i < obs0.size(); i++) begin
      chk("t2_sum", int'(obs0[i].s), 29);
      chk("t2_max", int'(obs0[i].m), 7);
    end

    // Stall the output for 6 cycles with input valid held high.
    obs0.delete();
    vld_pct[0] = 100; rdy_pct[0] = 0;
    for (int i = 0; i < 10; i++) src0.push_back(3'd1);
    for (int i = 0; i < 60 && !(hold_v[0] && src0.size() == 0); i++) step();
    chk("t3_emit", int'(hold_v[0]), 1);
    src0.push_back(3'd5); src0.push_back(3'd6);
    for (int i = 0; i < 8; i++) src0.push_back(3'd1);
    a = acc_cnt[0];
    run(6);
    chk("t3_accepted", acc_cnt[0] - a, 2);
    chk("t3_ready_low", int'(b0.d_ready), 0);
    chk("t3_sum_stable", int'(b0.sum_data), 10);
    rdy_pct[0] = 100;
    drain("t3_drain", 200);
    chk("t3_count", obs0.size(), 2);
    if (obs0.size() == 2) begin
      chk("t3_sum2", int'(obs0[1].s), 19);
      chk("t3_max2", int'(obs0[1].m), 6);
    end

    // Peak throughput with continuous valid and ready.
    for (int i = 0; i < 300; i++) src0.push_back(3'($urandom));
    run(55);
    a = acc_cnt[0];
    run(220);
    chk("t4_throughput", acc_cnt[0] - a, 200);
    drain("t4_drain", 200);

    // Reset mid-packet discards the partial sum.
    for (int i = 0; i < 4; i++) src0.push_back(3'd5);
    run(6);
    do_reset("mid");
    obs0.delete();
    for (int i = 0; i < 10; i++) src0.push_back(3'd1);
    drain("t5_drain", 200);
    chk("t5_count", obs0.size(), 1);
    if (obs0.size() == 1) begin
      chk("t5_sum", int'(obs0[0].s), 10);
      chk("t5_max", int'(obs0[0].m), 1);
    end

    // Reset while presenting: the pending packet must never appear.
    rdy_pct[0] = 0;
    for (int i = 0; i < 10; i++) src0.push_back(3'd2);
    for (int i = 0; i < 60 && !hold_v[0]; i++) step();
    chk("t6_emit", int'(hold_v[0]), 1);
    do_reset("emit");
    obs0.delete();
    rdy_pct[0] = 100;
    run(15);
    chk("t6_no_pkt", obs0.size(), 0);

    // Long random run on both instances.
    for (int i = 0; i < 10000; i++) src0.push_back(3'($urandom));
    for (int i = 0; i < 3000; i++) src1.push_back(3'($urandom));
    vld_pct[0] = 70; rdy_pct[0] = 60;
    vld_pct[1] = 70; rdy_pct[1] = 60;
    drain("rand_drain", 40000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
